// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - Shared op codes, FSM state type and defaults for the multiply/divide unit
// Contents:
//    DEFAULT_WIDTH  default operand and HI/LO width
//    OP_*           3-bit operation codes driven on the op field
//    state_t        iteration FSM states
//    f_is_signed    high for op codes that treat operands as two's complement
package muldiv_pkg;

   localparam int DEFAULT_WIDTH = 32;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MADD  = 3'd4;
   localparam logic [2:0] OP_MSUB  = 3'd5;
   localparam logic [2:0] OP_MTHI  = 3'd6;
   localparam logic [2:0] OP_MTLO  = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } state_t;

   function automatic logic f_is_signed(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - Issue/result bundle between the EXE/hazard logic and the multiply/divide unit
// Signals:
//    start, op, src_a, src_b  operation request from EXE (start held until accepted)
//    flush                    abort any in-flight operation
//    hilo_read                ID stage is issuing MFHI/MFLO
//    busy, stall              iteration in flight / pipeline freeze request
//    done, div_by_zero        one-cycle completion pulse and its divide-by-zero flag
//    hi, lo                   architectural HI/LO registers
// Modports: master = pipeline side, slave = muldiv_unit.
interface muldiv_if #(
   parameter int WIDTH = muldiv_pkg::DEFAULT_WIDTH
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             flush;
   logic             hilo_read;
   logic             busy;
   logic             stall;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, src_a, src_b, flush, hilo_read,
      input  busy, stall, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, flush, hilo_read,
      output busy, stall, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - One combinational radix-2 multiply or restoring-divide iteration
// Ports:
//    i_sub      0 = shift-add multiply step, 1 = restoring shift-subtract divide step
//    i_partial  partial product (upper half) or partial remainder
//    i_low      multiplier being consumed (LSB first) or dividend/quotient register (MSB first)
//    i_operand  multiplicand or divisor magnitude
//    o_partial  next partial product / remainder
//    o_low      next multiplier/quotient register with the new bit shifted in
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             i_sub,
   input  logic [WIDTH:0]   i_partial,
   input  logic [WIDTH-1:0] i_low,
   input  logic [WIDTH-1:0] i_operand,
   output logic [WIDTH:0]   o_partial,
   output logic [WIDTH-1:0] o_low
);
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH+1:0] w_diff;
   logic             w_borrow;

   // Multiply: add the multiplicand when the current multiplier LSB is set, then
   // shift the whole {partial, low} pair right so product bits fill low from the top.
   assign w_sum = i_partial + {1'b0, (i_low[0] ? i_operand : {WIDTH{1'b0}})};

   // Divide: bring the next dividend bit into the remainder, trial-subtract the divisor.
   assign w_shift  = {i_partial[WIDTH-1:0], i_low[WIDTH-1]};
   assign w_diff   = {1'b0, w_shift} - {2'b00, i_operand};
   assign w_borrow = w_diff[WIDTH+1];

   always_comb begin
      o_partial = '0;
      o_low     = '0;
      if (i_sub) begin
         if (w_borrow) begin
            o_partial = w_shift;
            o_low     = {i_low[WIDTH-2:0], 1'b0};
         end else begin
            o_partial = w_diff[WIDTH:0];
            o_low     = {i_low[WIDTH-2:0], 1'b1};
         end
      end else begin
         o_partial = {1'b0, w_sum[WIDTH:1]};
         o_low     = {w_sum[0], i_low[WIDTH-1:1]};
      end
   end
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - Iterative multiply/divide unit owning the HI/LO register pair
// Ports:
//    i_clk    sole clock, rising edge
//    i_rst_n  asynchronous active-low reset
//    bus      muldiv_if.slave: request (start/op/src_a/src_b), flush, hilo_read in;
//             busy, stall, done, div_by_zero, hi, lo out
// Operation: WIDTH shift-add or shift-subtract cycles on operand magnitudes, then one
// FIX cycle applies signs / accumulate and writes HI/LO. MTHI/MTLO load directly.
module muldiv_unit import muldiv_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic    i_clk,
   input  logic    i_rst_n,
   muldiv_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [2:0]         r_op;
   logic               r_sign_a;
   logic               r_sign_b;
   logic [WIDTH:0]     r_part;
   logic [WIDTH-1:0]   r_low;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;
   logic               r_dbz;

   logic               w_busy;
   logic               w_accept;
   logic               w_signed;
   logic               w_neg_a;
   logic               w_neg_b;
   logic               w_sub;
   logic [WIDTH:0]     w_step_part;
   logic [WIDTH-1:0]   w_step_low;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_s;
   logic               w_neg_res;
   logic               w_dbz;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic [2*WIDTH-1:0] w_hilo_nx;

   function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   assign w_busy   = (r_state != IDLE);
   assign w_accept = bus.start && !w_busy && !bus.flush;
   assign w_signed = f_is_signed(bus.op);
   assign w_neg_a  = w_signed & bus.src_a[WIDTH-1];
   assign w_neg_b  = w_signed & bus.src_b[WIDTH-1];
   assign w_sub    = (r_state == DIV);

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_sub     (w_sub),
      .i_partial (r_part),
      .i_low     (r_low),
      .i_operand (r_opnd),
      .o_partial (w_step_part),
      .o_low     (w_step_low)
   );

   // Result formation for the FIX cycle.
   always_comb begin
      w_prod    = {r_part[WIDTH-1:0], r_low};
      w_neg_res = r_sign_a ^ r_sign_b;
      w_prod_s  = w_neg_res ? -w_prod : w_prod;
      w_dbz     = (r_opnd == '0);
      // With a zero divisor every trial subtract succeeds, so the remainder path
      // already reproduces the dividend (sign restored below); only LO is forced.
      w_quo     = w_dbz ? {WIDTH{1'b1}} : (w_neg_res ? -r_low : r_low);
      w_rem     = r_sign_a ? -r_part[WIDTH-1:0] : r_part[WIDTH-1:0];
      w_hilo_nx = {r_hi, r_lo};
      case (r_op)
         OP_MULT, OP_MULTU: w_hilo_nx = w_prod_s;
         OP_MADD:           w_hilo_nx = {r_hi, r_lo} + w_prod_s;
         OP_MSUB:           w_hilo_nx = {r_hi, r_lo} - w_prod_s;
         OP_DIV, OP_DIVU:   w_hilo_nx = {w_rem, w_quo};
         default:           w_hilo_nx = {r_hi, r_lo};
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_op     <= '0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_part   <= '0;
         r_low    <= '0;
         r_opnd   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
         r_dbz    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_dbz  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op     <= bus.op;
                  r_sign_a <= w_neg_a;
                  r_sign_b <= w_neg_b;
                  r_part   <= '0;
                  r_cnt    <= CNT_W'(WIDTH - 1);
                  case (bus.op)
                     OP_MTHI: r_hi <= bus.src_a;
                     OP_MTLO: r_lo <= bus.src_a;
                     OP_DIV, OP_DIVU: begin
                        r_opnd  <= f_mag(bus.src_b, w_neg_b);
                        r_low   <= f_mag(bus.src_a, w_neg_a);
                        r_state <= DIV;
                     end
                     default: begin
                        r_opnd  <= f_mag(bus.src_a, w_neg_a);
                        r_low   <= f_mag(bus.src_b, w_neg_b);
                        r_state <= MUL;
                     end
                  endcase
               end
            end
            MUL, DIV: begin
               if (bus.flush) begin
                  r_state <= IDLE;
               end else begin
                  r_part <= w_step_part;
                  r_low  <= w_step_low;
                  if (r_cnt == '0) begin
                     r_state <= FIX;
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end
            end
            FIX: begin
               r_state <= IDLE;
               if (!bus.flush) begin
                  r_hi   <= w_hilo_nx[2*WIDTH-1:WIDTH];
                  r_lo   <= w_hilo_nx[WIDTH-1:0];
                  r_done <= 1'b1;
                  r_dbz  <= w_dbz && ((r_op == OP_DIV) || (r_op == OP_DIVU));
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy        = w_busy;
   assign bus.stall       = w_busy && (bus.start || bus.hilo_read);
   // Masked so a completion pulse can never coincide with a flush.
   assign bus.done        = r_done && !bus.flush;
   assign bus.div_by_zero = r_dbz && !bus.flush;
   assign bus.hi          = r_hi;
   assign bus.lo          = r_lo;
endmodule
